// File: rtl/wb_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_arb_pkg                                                       |
// | Shared definitions for the two-master wishbone GPIO arbiter:     |
// | arbiter state encoding and watchdog counter width.               |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package wb_arb_pkg;

   localparam int TCNT_W = 8;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_GNT0 = 2'd1,
      ARB_GNT1 = 2'd2,
      ARB_ERR  = 2'd3
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_arb_rr2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_arb_rr2                                                       |
// | Two-way round-robin picker. A lone requester always wins; on a   |
// | tie the master that was NOT granted last wins.                   |
// | Ports: req[1:0] requests, last = last master granted,            |
// |        pick[1:0] one-hot winner (0 when nobody requests).        |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module wb_arb_rr2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] pick
);

   always_comb begin
      pick = req;
      if (req == 2'b11) begin
         pick = last ? 2'b01 : 2'b10;
      end
   end

endmodule
`default_nettype wire

// File: rtl/wb_gpio_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_gpio_arbiter                                                  |
// | Shares one wishbone slave (GPIO) between two masters with        |
// | round-robin grant, data/ack steering, ack-drain handshake and a  |
// | per-transfer watchdog that errors the owner if no ack arrives.   |
// | Ports: clk, rst (async, active low); mN_* master N bus (N=0,1);  |
// |        s_* slave bus; s_int_i/int_o interrupt; grant_o debug.    |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module wb_gpio_arbiter
   import wb_arb_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_sel_i,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   output logic [31:0] m0_dat_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_sel_i,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   output logic [31:0] m1_dat_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [3:0]  s_sel_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   input  logic        s_int_i,
   output logic        int_o,
   output logic [1:0]  grant_o
);

   // Counter value at which a still-unacked strobe trips the watchdog.
   // The error becomes visible TIMEOUT+1 cycles after the strobe rose.
   localparam logic [TCNT_W-1:0] c_TCNT_LIMIT = TCNT_W'(TIMEOUT);

   arb_state_t        r_state;
   logic              r_last;
   logic              r_drain;
   logic [TCNT_W-1:0] r_tcnt;
   logic              r_int;

   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_stb_sel;
   logic              w_ack;
   logic              w_wait;
   logic              w_own_cyc;
   logic [1:0]        w_req;
   logic [1:0]        w_pick;

   assign w_gnt0 = (r_state == ARB_GNT0);
   assign w_gnt1 = (r_state == ARB_GNT1);

   assign w_req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

   wb_arb_rr2 u_rr2 (
      .req  (w_req),
      .last (r_last),
      .pick (w_pick)
   );

   // Slave-side steering: only a live grant drives the slave bus.
   always_comb begin
      w_stb_sel = 1'b0;
      s_cyc_o   = 1'b0;
      s_we_o    = 1'b0;
      s_sel_o   = '0;
      s_adr_o   = '0;
      s_dat_o   = '0;
      if (w_gnt0) begin
         w_stb_sel = m0_stb_i;
         s_cyc_o   = m0_cyc_i;
         s_we_o    = m0_we_i;
         s_sel_o   = m0_sel_i;
         s_adr_o   = m0_adr_i;
         s_dat_o   = m0_dat_i;
      end else if (w_gnt1) begin
         w_stb_sel = m1_stb_i;
         s_cyc_o   = m1_cyc_i;
         s_we_o    = m1_we_i;
         s_sel_o   = m1_sel_i;
         s_adr_o   = m1_adr_i;
         s_dat_o   = m1_dat_i;
      end
   end

   // Strobe is masked while draining so a held slave ack is never
   // mistaken for the acknowledge of the next transfer.
   assign s_stb_o   = w_stb_sel & ~r_drain;
   assign w_ack     = s_ack_i & s_stb_o;
   assign w_wait    = s_stb_o & ~s_ack_i;
   // In GNT/ERR r_last always names the owning master.
   assign w_own_cyc = r_last ? m1_cyc_i : m0_cyc_i;

   assign m0_ack_o = w_ack & w_gnt0;
   assign m1_ack_o = w_ack & w_gnt1;
   assign m0_dat_o = w_gnt0 ? s_dat_i : '0;
   assign m1_dat_o = w_gnt1 ? s_dat_i : '0;
   assign m0_err_o = (r_state == ARB_ERR) & ~r_last;
   assign m1_err_o = (r_state == ARB_ERR) &  r_last;
   assign grant_o  = {w_gnt1, w_gnt0};
   assign int_o    = r_int;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ARB_IDLE;
         r_last  <= 1'b1;
         r_drain <= 1'b0;
         r_tcnt  <= '0;
         r_int   <= 1'b0;
      end else begin
         r_int <= s_int_i;
         case (r_state)
            ARB_IDLE: begin
               r_drain <= 1'b0;
               r_tcnt  <= '0;
               if (w_pick[0]) begin
                  r_state <= ARB_GNT0;
                  r_last  <= 1'b0;
               end else if (w_pick[1]) begin
                  r_state <= ARB_GNT1;
                  r_last  <= 1'b1;
               end
            end

            ARB_GNT0, ARB_GNT1: begin
               if (w_ack) begin
                  r_drain <= 1'b1;
               end else if (!s_ack_i) begin
                  r_drain <= 1'b0;
               end

               if (w_wait) begin
                  if (r_tcnt == c_TCNT_LIMIT) begin
                     r_state <= ARB_ERR;
                     r_tcnt  <= '0;
                  end else begin
                     r_tcnt <= r_tcnt + TCNT_W'(1);
                  end
               end else begin
                  r_tcnt <= '0;
               end

               // Release waits for the slave to drop a pending ack so the
               // next owner never inherits it.
               if (!w_own_cyc && !r_drain && !w_ack) begin
                  r_state <= ARB_IDLE;
                  r_tcnt  <= '0;
               end
            end

            ARB_ERR: begin
               r_drain <= 1'b0;
               r_tcnt  <= '0;
               if (!w_own_cyc) begin
                  r_state <= ARB_IDLE;
               end
            end

            default: r_state <= ARB_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wb_gpio_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_wb_gpio_arbiter                                               |
// | Self-checking bench for wb_gpio_arbiter: vector table, directed  |
// | multi-cycle sequences and random traffic against a reference.    |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_wb_gpio_arbiter;

   localparam int TMO = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        m0_cyc_i, m0_stb_i, m0_we_i;
   logic [3:0]  m0_sel_i;
   logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
   logic        m0_ack_o, m0_err_o;
   logic        m1_cyc_i, m1_stb_i, m1_we_i;
   logic [3:0]  m1_sel_i;
   logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
   logic        m1_ack_o, m1_err_o;
   logic        s_cyc_o, s_stb_o, s_we_o;
   logic [3:0]  s_sel_o;
   logic [31:0] s_adr_o, s_dat_o, s_dat_i;
   logic        s_ack_i, s_int_i, int_o;
   logic [1:0]  grant_o;

   wb_gpio_arbiter #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
      .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
      .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
      .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
      .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_int_i(s_int_i),
      .int_o(int_o), .grant_o(grant_o)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // owner: -1 nobody, else master index; erred: owner timed out.
   int   mo_owner, mo_last, mo_wait;
   bit   mo_err, mo_drain, mo_int;
   logic e_scyc, e_sstb, e_swe, e_ack0, e_ack1, e_err0, e_err1, e_int;
   logic [3:0]  e_ssel;
   logic [31:0] e_sadr, e_sdat, e_dat0, e_dat1;
   logic [1:0]  e_grant;

   // bench-side registered-ack slave
   bit slave_auto, slave_en, sack_q;

   // observations of the last evaluated cycle
   logic obs_stb, obs_scyc, obs_swe, obs_ack0, obs_ack1, obs_err0;
   logic [31:0] obs_sadr, obs_sdat, obs_m1dat, drv_sdat;
   logic [1:0]  obs_grant;

   task automatic model_reset();
      mo_owner = -1; mo_last = 1; mo_wait = 0;
      mo_err = 0; mo_drain = 0; mo_int = 0; sack_q = 0;
   endtask

   task automatic model_eval();
      bit g;
      logic stbm;
      g = (mo_owner >= 0) && !mo_err;
      stbm = 1'b0;
      e_scyc = 0; e_swe = 0; e_ssel = '0; e_sadr = '0; e_sdat = '0;
      if (g && mo_owner == 0) begin
         e_scyc = m0_cyc_i; stbm = m0_stb_i; e_swe = m0_we_i;
         e_ssel = m0_sel_i; e_sadr = m0_adr_i; e_sdat = m0_dat_i;
      end else if (g) begin
         e_scyc = m1_cyc_i; stbm = m1_stb_i; e_swe = m1_we_i;
         e_ssel = m1_sel_i; e_sadr = m1_adr_i; e_sdat = m1_dat_i;
      end
      e_sstb  = stbm && !mo_drain;
      e_ack0  = g && mo_owner == 0 && s_ack_i && e_sstb;
      e_ack1  = g && mo_owner == 1 && s_ack_i && e_sstb;
      e_dat0  = (g && mo_owner == 0) ? s_dat_i : 32'h0;
      e_dat1  = (g && mo_owner == 1) ? s_dat_i : 32'h0;
      e_err0  = mo_err && mo_owner == 0;
      e_err1  = mo_err && mo_owner == 1;
      e_grant = !g ? 2'b00 : (mo_owner == 0 ? 2'b01 : 2'b10);
      e_int   = mo_int;
   endtask

   task automatic model_step();
      bit r0, r1, ocyc, acked, old_drain;
      int w;
      if (slave_auto) sack_q = e_sstb && (slave_en || s_ack_i);
      mo_int = s_int_i;
      if (mo_owner < 0) begin
         r0 = m0_cyc_i && m0_stb_i;
         r1 = m1_cyc_i && m1_stb_i;
         w = (r0 && r1) ? 1 - mo_last : (r0 ? 0 : (r1 ? 1 : -1));
         if (w >= 0) begin mo_owner = w; mo_last = w; end
         mo_drain = 0; mo_wait = 0;
      end else begin
         ocyc = (mo_owner == 0) ? m0_cyc_i : m1_cyc_i;
         if (mo_err) begin
            if (!ocyc) begin mo_owner = -1; mo_err = 0; end
         end else begin
            acked = e_ack0 || e_ack1;
            old_drain = mo_drain;
            if (acked) mo_drain = 1;
            else if (!s_ack_i) mo_drain = 0;
            // error once the strobe has gone unacked for TMO+1 cycles
            if (e_sstb && !s_ack_i) begin
               mo_wait++;
               if (mo_wait > TMO) begin mo_err = 1; mo_wait = 0; end
            end else begin
               mo_wait = 0;
            end
            if (!ocyc && !old_drain && !acked) begin
               mo_owner = -1; mo_err = 0; mo_wait = 0;
            end
         end
      end
   endtask

   function automatic logic [141:0] dut_vec();
      return {m0_dat_o, m0_ack_o, m0_err_o, m1_dat_o, m1_ack_o, m1_err_o,
              s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, int_o, grant_o};
   endfunction

   function automatic logic [141:0] exp_vec();
      return {e_dat0, e_ack0, e_err0, e_dat1, e_ack1, e_err1,
              e_scyc, e_sstb, e_swe, e_ssel, e_sadr, e_sdat, e_int, e_grant};
   endfunction

   // One clock: entered just after a rising edge with master inputs set.
   task automatic cycle(input string name);
      s_dat_i = $urandom;
      s_int_i = 1'($urandom_range(0, 1));
      if (slave_auto) s_ack_i = sack_q;
      @(negedge clk);
      model_eval();
      chk(name, dut_vec(), exp_vec());
      obs_stb = s_stb_o; obs_scyc = s_cyc_o; obs_swe = s_we_o;
      obs_ack0 = m0_ack_o; obs_ack1 = m1_ack_o; obs_err0 = m0_err_o;
      obs_sadr = s_adr_o; obs_sdat = s_dat_o; obs_m1dat = m1_dat_o;
      obs_grant = grant_o; drv_sdat = s_dat_i;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_master(inout logic cyc, inout logic stb, output logic we,
                              output logic [3:0] sel, output logic [31:0] adr,
                              output logic [31:0] dat);
      if (cyc) begin
         if ($urandom_range(0, 5) == 0) begin cyc = 0; stb = 0; end
         else stb = ($urandom_range(0, 3) != 0);
      end else if ($urandom_range(0, 3) == 0) begin
         cyc = 1; stb = 1;
      end
      we = 1'($urandom_range(0, 1));
      sel = 4'($urandom);
      adr = $urandom;
      dat = $urandom;
   endtask

   typedef struct {
      logic m0c, m0s, m1c, m1s, sack;
      logic [1:0] grant;
      logic sstb, a0, a1;
   } vec_t;

   vec_t tbl[14];

   initial begin
      int acks, extra, t_stb, t_err;
      bit prev_ack;

      // rows: m0 cyc/stb, m1 cyc/stb, slave ack -> grant, s_stb, m0 ack, m1 ack
      tbl[0]  = '{0,0,0,0,0, 2'b00,0,0,0};
      tbl[1]  = '{1,1,1,1,0, 2'b00,0,0,0};  // tie seen in IDLE
      tbl[2]  = '{1,1,1,1,0, 2'b01,1,0,0};  // m0 wins first tie
      tbl[3]  = '{1,1,1,1,1, 2'b01,1,1,0};  // ack
      tbl[4]  = '{1,0,1,1,1, 2'b01,0,0,0};  // drain, ack still high
      tbl[5]  = '{0,0,1,1,0, 2'b01,0,0,0};  // cyc gone but still draining
      tbl[6]  = '{0,0,1,1,0, 2'b01,0,0,0};  // release edge
      tbl[7]  = '{0,0,1,1,0, 2'b00,0,0,0};  // one idle cycle between owners
      tbl[8]  = '{0,0,1,1,0, 2'b10,1,0,0};
      tbl[9]  = '{0,0,1,1,1, 2'b10,1,0,1};
      tbl[10] = '{0,0,0,0,1, 2'b10,0,0,0};
      tbl[11] = '{0,0,0,0,0, 2'b10,0,0,0};
      tbl[12] = '{0,0,0,0,0, 2'b10,0,0,0};
      tbl[13] = '{0,0,0,0,0, 2'b00,0,0,0};

      rst = 0;
      m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 0; m0_adr_i = 0; m0_dat_i = 0;
      m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 0; m1_adr_i = 0; m1_dat_i = 0;
      s_dat_i = 32'hDEAD_BEEF; s_ack_i = 0; s_int_i = 1;
      slave_auto = 0; slave_en = 1;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 160'(dut_vec()), 160'h0);
      @(posedge clk);
      #1;
      rst = 1;

      // ---- vector table: tie, drain, release spacing ----
      for (int i = 0; i < 14; i++) begin
         m0_cyc_i = tbl[i].m0c; m0_stb_i = tbl[i].m0s;
         m1_cyc_i = tbl[i].m1c; m1_stb_i = tbl[i].m1s;
         s_ack_i = tbl[i].sack;
         cycle("tbl_model");
         chk($sformatf("tbl_row%0d", i), {obs_grant, obs_stb, obs_ack0, obs_ack1},
             {tbl[i].grant, tbl[i].sstb, tbl[i].a0, tbl[i].a1});
      end

      // ---- single master write ----
      slave_auto = 1; slave_en = 1; sack_q = 0;
      m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 4'hF;
      m0_adr_i = 32'h0; m0_dat_i = 32'h0000_00A5;
      cycle("wr_model");
      chk("wr_idle_stb", obs_stb, 0);
      cycle("wr_model");
      chk("wr_stb_latency", obs_stb, 1);
      chk("wr_slave_bus", {obs_swe, obs_sadr, obs_sdat}, {1'b1, 32'h0, 32'h0000_00A5});
      acks = 0;
      cycle("wr_model");
      chk("wr_ack", obs_ack0, 1);
      acks += int'(obs_ack0);
      cycle("wr_model");
      chk("wr_drain_stb", {obs_stb, s_ack_i}, 2'b01);
      acks += int'(obs_ack0);
      m0_cyc_i = 0; m0_stb_i = 0;
      repeat (3) begin
         cycle("wr_model");
         acks += int'(obs_ack0);
      end
      chk("wr_ack_count", acks, 1);

      // ---- back-to-back reads by m1 ----
      m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_sel_i = 4'hF; m1_adr_i = 32'h1;
      acks = 0; prev_ack = 0;
      for (int k = 0; k < 40 && acks < 3; k++) begin
         cycle("b2b_model");
         if (prev_ack) chk("b2b_drain", obs_stb, 0);
         prev_ack = obs_ack1;
         if (obs_ack1) begin
            acks++;
            chk("b2b_rdata", obs_m1dat, drv_sdat);
            if (acks == 3) begin m1_cyc_i = 0; m1_stb_i = 0; end
         end
      end
      chk("b2b_ack_count", acks, 3);
      extra = 0;
      repeat (6) begin
         cycle("b2b_model");
         extra += int'(obs_ack1);
      end
      chk("b2b_no_extra_ack", extra, 0);

      // ---- watchdog timeout with m1 waiting, then round robin ----
      slave_en = 0;
      m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0;
      m1_cyc_i = 1; m1_stb_i = 1;
      t_stb = -1; t_err = -1;
      for (int k = 0; k < 20; k++) begin
         cycle("tmo_model");
         if (obs_stb && t_stb < 0) t_stb = k;
         if (obs_err0) begin t_err = k; break; end
      end
      chk("tmo_err_seen", t_err >= 0, 1);
      chk("tmo_latency", t_err - t_stb, TMO + 1);
      chk("tmo_slave_idle", {obs_scyc, obs_stb}, 2'b00);
      cycle("tmo_model");
      chk("tmo_err_held", obs_err0, 1);
      m0_cyc_i = 0; m0_stb_i = 0;
      cycle("tmo_model");
      m0_cyc_i = 1; m0_stb_i = 1;
      cycle("tmo_model");
      cycle("tmo_model");
      chk("rr_after_err", obs_grant, 2'b10);
      chk("rr_after_err_stb", obs_stb, 1);

      // ---- asynchronous reset mid-transfer ----
      #2;
      rst = 0;
      #1;
      chk("rst_async", 160'(dut_vec()), 160'h0);
      @(posedge clk);
      #1;
      rst = 1;
      model_reset();
      s_ack_i = 0;
      cycle("rst_model");
      cycle("rst_model");
      chk("rst_tie_m0", obs_grant, 2'b01);
      m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
      slave_en = 1;
      repeat (4) cycle("rst_model");

      // ---- random traffic against the model ----
      for (int n = 0; n < 800; n++) begin
         rand_master(m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i);
         rand_master(m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i);
         if ($urandom_range(0, 15) == 0) slave_en = !slave_en;
         cycle("rand_model");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
